// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/branch/MUL-DIV stall and flush control for the 5-stage pipeline,
// with a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int MD_LATENCY = 4,
   parameter int FWD_DECODE = 1,
   parameter int PERF_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  branchD,
   input  logic                  pc_srcD,
   input  logic [REG_ADDR_W-1:0] rsD,
   input  logic [REG_ADDR_W-1:0] rtD,
   input  logic [REG_ADDR_W-1:0] rsE,
   input  logic [REG_ADDR_W-1:0] rtE,
   input  logic [REG_ADDR_W-1:0] rf_waE,
   input  logic [REG_ADDR_W-1:0] rf_waM,
   input  logic [REG_ADDR_W-1:0] rf_waW,
   input  logic                  we_regE,
   input  logic                  we_regM,
   input  logic                  we_regW,
   input  logic                  dm2regE,
   input  logic                  dm2regM,
   input  logic                  mdstartE,
   output logic                  ForwardAD,
   output logic                  ForwardBD,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  stallF,
   output logic                  stallD,
   output logic                  stallE,
   output logic                  flushD,
   output logic                  flushE,
   output logic                  flushM,
   output logic                  md_busy,
   output logic [PERF_W-1:0]     stall_cnt
);
   localparam int CW = $clog2(MD_LATENCY) + 1;
   localparam logic [CW-1:0] MD_LAST = CW'(MD_LATENCY - 1);
   logic [CW-1:0]     md_cnt_q, md_cnt_d;
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   logic match_e, match_m, lwstall, branchstall, mdstall, hz;
   always_comb begin
      match_e     = rf_waE != '0 && (rf_waE == rsD || rf_waE == rtD);
      match_m     = rf_waM != '0 && (rf_waM == rsD || rf_waM == rtD);
      lwstall     = dm2regE && match_e;
      branchstall = branchD && ((we_regE && match_e) || (dm2regM && match_m) ||
                                (FWD_DECODE == 0 && we_regM && match_m));
      mdstall     = mdstartE && md_cnt_q < MD_LAST;
      hz          = lwstall || branchstall;
      md_cnt_d    = mdstall ? md_cnt_q + 1'b1 : '0;
      // every output is forced low while reset is asserted
      stallF      = rst_n && (mdstall || hz);
      stallD      = stallF;
      stallE      = rst_n && mdstall;
      flushM      = stallE;
      md_busy     = stallE;
      flushE      = rst_n && !mdstall && hz;
      flushD      = rst_n && pc_srcD && !stallD;
      ForwardAD   = rst_n && FWD_DECODE != 0 && branchD && we_regM && rf_waM != '0 && rf_waM == rsD;
      ForwardBD   = rst_n && FWD_DECODE != 0 && branchD && we_regM && rf_waM != '0 && rf_waM == rtD;
      ForwardAE   = !rst_n ? 2'b00 :
                    (we_regM && rsE != '0 && rf_waM == rsE) ? 2'b10 :
                    (we_regW && rsE != '0 && rf_waW == rsE) ? 2'b01 : 2'b00;
      ForwardBE   = !rst_n ? 2'b00 :
                    (we_regM && rtE != '0 && rf_waM == rtE) ? 2'b10 :
                    (we_regW && rtE != '0 && rf_waW == rtE) ? 2'b01 : 2'b00;
      stall_cnt_d = (stallF && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      stall_cnt   = stall_cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         md_cnt_q    <= md_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks of hazard_ctrl with forwarding to D on and off.
module tb_hazard_ctrl;
   logic clk = 1'b0, rst_n = 1'b0;
   logic branchD, pc_srcD, we_regE, we_regM, we_regW, dm2regE, dm2regM, mdstartE;
   logic [4:0] rsD, rtD, rsE, rtE, rf_waE, rf_waM, rf_waW;
   logic fad_a, fbd_a, stF_a, stD_a, stE_a, flD_a, flE_a, flM_a, busy_a;
   logic fad_b, fbd_b, stF_b, stD_b, stE_b, flD_b, flE_b, flM_b, busy_b;
   logic [1:0] fae_a, fbe_a, fae_b, fbe_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(4), .FWD_DECODE(1), .PERF_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .branchD(branchD), .pc_srcD(pc_srcD), .rsD(rsD), .rtD(rtD),
      .rsE(rsE), .rtE(rtE), .rf_waE(rf_waE), .rf_waM(rf_waM), .rf_waW(rf_waW),
      .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW), .dm2regE(dm2regE),
      .dm2regM(dm2regM), .mdstartE(mdstartE), .ForwardAD(fad_a), .ForwardBD(fbd_a),
      .ForwardAE(fae_a), .ForwardBE(fbe_a), .stallF(stF_a), .stallD(stD_a), .stallE(stE_a),
      .flushD(flD_a), .flushE(flE_a), .flushM(flM_a), .md_busy(busy_a), .stall_cnt(cnt_a));

   hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(4), .FWD_DECODE(0), .PERF_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .branchD(branchD), .pc_srcD(pc_srcD), .rsD(rsD), .rtD(rtD),
      .rsE(rsE), .rtE(rtE), .rf_waE(rf_waE), .rf_waM(rf_waM), .rf_waW(rf_waW),
      .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW), .dm2regE(dm2regE),
      .dm2regM(dm2regM), .mdstartE(mdstartE), .ForwardAD(fad_b), .ForwardBD(fbd_b),
      .ForwardAE(fae_b), .ForwardBE(fbe_b), .stallF(stF_b), .stallD(stD_b), .stallE(stE_b),
      .flushD(flD_b), .flushE(flE_b), .flushM(flM_b), .md_busy(busy_b), .stall_cnt(cnt_b));

   typedef struct {
      logic       br, pcs;
      logic [4:0] rsd, rtd, rse, rte, wae, wam, waw;
      logic       wee, wem, wew, lwe, lwm, md;
      logic [12:0] exp_a;
      logic [3:0]  exp_b;
   } vec_t;
   vec_t vt[13];

   function automatic logic [12:0] bundle_a();
      return {fad_a, fbd_a, fae_a, fbe_a, stF_a, stD_a, stE_a, flD_a, flE_a, flM_a, busy_a};
   endfunction

   function automatic logic [12:0] bundle_b_full();
      return {fad_b, fbd_b, fae_b, fbe_b, stF_b, stD_b, stE_b, flD_b, flE_b, flM_b, busy_b};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      branchD = 0; pc_srcD = 0; rsD = 0; rtD = 0; rsE = 0; rtE = 0;
      rf_waE = 0; rf_waM = 0; rf_waW = 0; we_regE = 0; we_regM = 0; we_regW = 0;
      dm2regE = 0; dm2regM = 0; mdstartE = 0;
   endtask

   task automatic load_use();
      idle(); dm2regE = 1; rf_waE = 8; rtD = 8;
   endtask

   task automatic do_reset();
      @(negedge clk); idle(); rst_n = 0;
      @(negedge clk); rst_n = 1;
   endtask

   initial begin
      //          br pcs rsd rtd rse rte wae wam waw wee wem wew lwe lwm md  exp_a                exp_b
      vt[0]  = '{0, 0,  0,  0,  0,  0,  0,  0,  0, 0,  0,  0,  0,  0,  0, 13'b00_00_00_0000000, 4'b0000};
      vt[1]  = '{0, 0,  0,  0,  3,  3,  0,  3,  3, 0,  1,  1,  0,  0,  0, 13'b00_10_10_0000000, 4'b0000};
      vt[2]  = '{0, 0,  0,  0,  3,  3,  0,  3,  3, 0,  0,  1,  0,  0,  0, 13'b00_01_01_0000000, 4'b0000};
      vt[3]  = '{0, 0,  0,  0,  0,  3,  0,  3,  3, 0,  0,  1,  0,  0,  0, 13'b00_00_01_0000000, 4'b0000};
      vt[4]  = '{0, 0,  0,  0,  0,  0,  0,  0,  0, 0,  1,  1,  0,  0,  0, 13'b00_00_00_0000000, 4'b0000};
      vt[5]  = '{0, 0,  0,  8,  0,  0,  8,  0,  0, 0,  0,  0,  1,  0,  0, 13'b00_00_00_1100100, 4'b0010};
      vt[6]  = '{0, 0,  0,  0,  0,  0,  0,  0,  0, 0,  0,  0,  1,  0,  0, 13'b00_00_00_0000000, 4'b0000};
      vt[7]  = '{1, 0,  5,  0,  0,  0,  0,  5,  0, 0,  1,  0,  0,  0,  0, 13'b10_00_00_0000000, 4'b0010};
      vt[8]  = '{1, 1,  5,  0,  0,  0,  0,  5,  0, 0,  1,  0,  0,  0,  0, 13'b10_00_00_0001000, 4'b0010};
      vt[9]  = '{1, 1,  0,  7,  0,  0,  7,  0,  0, 1,  0,  0,  0,  0,  0, 13'b00_00_00_1100100, 4'b0010};
      vt[10] = '{1, 0,  9,  0,  0,  0,  0,  9,  0, 0,  1,  0,  0,  1,  0, 13'b10_00_00_1100100, 4'b0010};
      vt[11] = '{1, 0,  0,  4,  0,  0,  0,  4,  0, 0,  1,  0,  0,  0,  0, 13'b01_00_00_0000000, 4'b0010};
      vt[12] = '{0, 0,  0,  8,  0,  0,  8,  0,  0, 0,  0,  0,  1,  0,  1, 13'b00_00_00_1110011, 4'b0010};

      // reset: outputs forced low even with hazards present
      idle(); mdstartE = 1; dm2regE = 1; rf_waE = 8; rtD = 8; branchD = 1; pc_srcD = 1;
      #2;
      chk("reset_out_a", 32'(bundle_a()), 0);
      chk("reset_out_b", 32'(bundle_b_full()), 0);
      chk("reset_cnt_a", 32'(cnt_a), 0);
      do_reset();

      foreach (vt[i]) begin
         @(negedge clk);
         {branchD, pc_srcD, rsD, rtD, rsE, rtE} = {vt[i].br, vt[i].pcs, vt[i].rsd, vt[i].rtd, vt[i].rse, vt[i].rte};
         {rf_waE, rf_waM, rf_waW, we_regE, we_regM, we_regW} = {vt[i].wae, vt[i].wam, vt[i].waw, vt[i].wee, vt[i].wem, vt[i].wew};
         {dm2regE, dm2regM, mdstartE} = {vt[i].lwe, vt[i].lwm, vt[i].md};
         #2;
         chk($sformatf("vec%0d_a", i), 32'(bundle_a()), 32'(vt[i].exp_a));
         chk($sformatf("vec%0d_b", i), 32'({fad_b, fbd_b, stF_b, flD_b}), 32'(vt[i].exp_b));
      end

      // load-use: one stall cycle, counter lags by one edge
      do_reset();
      @(negedge clk); load_use(); #2;
      chk("lu_stall", 32'({stF_a, stD_a, flE_a, stE_a}), 32'b1110);
      chk("lu_cnt0", 32'(cnt_a), 0);
      @(negedge clk); idle(); #2;
      chk("lu_cnt1", 32'(cnt_a), 1);
      chk("lu_nostall", 32'(stF_a), 0);
      @(negedge clk); #2;
      chk("lu_cnt_hold", 32'(cnt_a), 1);

      // MUL/DIV with a concurrent load-use: masked for 3 cycles, visible on the advance cycle
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); load_use(); mdstartE = 1; #2;
         if (c == 3) chk("md_adv", 32'({busy_a, stE_a, flM_a, stF_a, flE_a}), 32'b00011);
         else        chk($sformatf("md_c%0d", c), 32'({busy_a, stE_a, flM_a, stF_a, flE_a}), 32'b11110);
      end
      chk("md_cnt_stalls", 32'(cnt_a), 4);

      // saturation: 20 stall cycles on the 4-bit counter
      do_reset();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); load_use();
      end
      @(negedge clk); idle(); #2;
      chk("sat_b", 32'(cnt_b), 15);
      chk("sat_a", 32'(cnt_a), 20);

      // asynchronous reset mid MUL/DIV stall, then a clean restart
      @(negedge clk); idle(); mdstartE = 1; #2;
      chk("ar_busy0", 32'(busy_a), 1);
      @(negedge clk); #1 rst_n = 0; #1;
      chk("ar_out_a", 32'(bundle_a()), 0);
      chk("ar_out_b", 32'(bundle_b_full()), 0);
      chk("ar_cnt_a", 32'(cnt_a), 0);
      chk("ar_cnt_b", 32'(cnt_b), 0);
      @(negedge clk); rst_n = 1;
      for (int c = 0; c < 4; c++) begin
         #2;
         chk($sformatf("ar_restart%0d", c), 32'(busy_a), (c < 3) ? 1 : 0);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
